// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - operand, handshake and HI/LO bundle for mul_div_unit
interface mul_div_unit_if #(
    parameter int Dbits = 32
);
    logic             start;
    logic [1:0]       op;
    logic [Dbits-1:0] a;
    logic [Dbits-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [Dbits-1:0] wdata;
    logic             busy;
    logic             done;
    logic [Dbits-1:0] hi;
    logic [Dbits-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO; divider built only with MULDIV_DIV_EN
module mul_div_unit #(
    parameter int Dbits = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    mul_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam int CW = $clog2(Dbits + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              div_q, div_d;
    logic              neg_q, neg_d;
    logic [2*Dbits-1:0] acc_q, acc_d;
    logic [Dbits-1:0]  opb_q, opb_d;
    logic [Dbits-1:0]  hi_q, hi_d;
    logic [Dbits-1:0]  lo_q, lo_d;
    logic              done_q, done_d;

    // Operand magnitudes and sign flags; unsigned ops never see a sign.
    logic              is_signed, sign_a, sign_b;
    logic [Dbits-1:0]  mag_a, mag_b;
    assign is_signed = ~bus.op[0];
    assign sign_a    = is_signed & bus.a[Dbits-1];
    assign sign_b    = is_signed & bus.b[Dbits-1];
    assign mag_a     = sign_a ? -bus.a : bus.a;
    assign mag_b     = sign_b ? -bus.b : bus.b;

    // Shift-add: acc holds {partial product, remaining multiplier bits}.
    logic [Dbits:0]     mul_sum;
    logic [2*Dbits-1:0] prod_fix;
    assign mul_sum  = {1'b0, acc_q[2*Dbits-1:Dbits]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
    // Restoring divide: acc low half shifts dividend bits out and quotient bits in.
    logic [Dbits-1:0] rem_q, rem_d;
    logic             nega_q, nega_d;
    logic             bzero_q, bzero_d;
    logic [Dbits:0]   div_shift, div_trial;
    logic [Dbits-1:0] quo_fix, rem_fix;
    assign div_shift = {rem_q, acc_q[Dbits-1]};
    assign div_trial = div_shift - {1'b0, opb_q};
    assign quo_fix   = neg_q ? -acc_q[Dbits-1:0] : acc_q[Dbits-1:0];
    assign rem_fix   = nega_q ? -rem_q : rem_q;
`endif

    // Next-state, datapath step and HI/LO update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
        rem_d   = rem_q;
        nega_d  = nega_q;
        bzero_d = bzero_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    div_d   = bus.op[1];
                    neg_d   = sign_a ^ sign_b;
                    cnt_d   = CW'(Dbits);
                    state_d = RUN;
                    if (bus.op[1]) begin
                        acc_d = {{Dbits{1'b0}}, mag_a};
                        opb_d = mag_b;
                    end else begin
                        acc_d = {{Dbits{1'b0}}, mag_b};
                        opb_d = mag_a;
                    end
`ifdef MULDIV_DIV_EN
                    rem_d   = '0;
                    nega_d  = sign_a;
                    bzero_d = (bus.b == '0);
`endif
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (div_q) begin
`ifdef MULDIV_DIV_EN
                    rem_d = div_trial[Dbits] ? div_shift[Dbits-1:0] : div_trial[Dbits-1:0];
                    acc_d = {acc_q[2*Dbits-1:Dbits], acc_q[Dbits-2:0], ~div_trial[Dbits]};
`endif
                end else begin
                    acc_d = {mul_sum, acc_q[Dbits-1:1]};
                end
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (div_q) begin
`ifdef MULDIV_DIV_EN
                    hi_d = rem_fix;
                    lo_d = bzero_q ? '1 : quo_fix;
`else
                    hi_d = '0;
                    lo_d = '0;
`endif
                end else begin
                    hi_d = prod_fix[2*Dbits-1:Dbits];
                    lo_d = prod_fix[Dbits-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            rem_q   <= '0;
            nega_q  <= 1'b0;
            bzero_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_DIV_EN
            rem_q   <= rem_d;
            nega_q  <= nega_d;
            bzero_q <= bzero_d;
`endif
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;
    logic clock;
    logic reset_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    mul_div_unit_if #(.Dbits(32)) bus();

    mul_div_unit #(.Dbits(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] cur_hi, cur_lo, prev_hi, prev_lo;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clock) begin
        if (reset_n && bus.done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_hi", {32'h0, bus.hi}, {32'h0, e.hi});
                check("result_lo", {32'h0, bus.lo}, {32'h0, e.lo});
                check("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Launch from posedge+1; returns at E0+1 with the expectation queued.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clock);
        #1;
        sb.push_back('{ehi, elo, cyc + 33});
        bus.start = 1'b0;
        prev_hi   = cur_hi;
        prev_lo   = cur_lo;
        cur_hi    = ehi;
        cur_lo    = elo;
    endtask

    task automatic div_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
`ifdef MULDIV_DIV_EN
        start_op(op, a, b, ehi, elo);
`else
        start_op(op, a, b, 32'h0, 32'h0);
`endif
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 60) begin
            wait_cycles(1);
            k++;
        end
        check("idle_timeout", {63'h0, bus.busy}, 64'h0);
        wait_cycles(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        cur_hi    = '0;
        cur_lo    = '0;
        prev_hi   = '0;
        prev_lo   = '0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        #2;
        check("reset_hi",   {32'h0, bus.hi}, 64'h0);
        check("reset_lo",   {32'h0, bus.lo}, 64'h0);
        check("reset_busy", {63'h0, bus.busy}, 64'h0);
        check("reset_done", {63'h0, bus.done}, 64'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_cycles(1);

        // MULTU max*max with busy/done timing around E32/E33.
        start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        wait_cycles(32);
        check("busy_at_e32", {63'h0, bus.busy}, 64'h1);
        check("hi_stable_run", {32'h0, bus.hi}, {32'h0, prev_hi});
        wait_cycles(1);
        check("busy_after_e33", {63'h0, bus.busy}, 64'h0);
        check("done_after_e33", {63'h0, bus.done}, 64'h1);
        wait_cycles(1);
        check("done_drops", {63'h0, bus.done}, 64'h0);

        start_op(2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB); wait_idle();
        start_op(2'b00, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'h0, 32'd20);       wait_idle();
        start_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0); wait_idle();
        div_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);   wait_idle();
        div_op(2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);        wait_idle();
        div_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);   wait_idle();
        div_op(2'b10, 32'd9, 32'd3, 32'h0, 32'd3);                        wait_idle();
        div_op(2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);   wait_idle();
        div_op(2'b10, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);        wait_idle();
        div_op(2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);   wait_idle();
        div_op(2'b11, 32'hFFFFFFFF, 32'd16, 32'd15, 32'h0FFFFFFF);        wait_idle();

        // MTHI during RUN and a second start at E5 must both be ignored.
        start_op(2'b01, 32'd6, 32'd7, 32'h0, 32'd42);
        wait_cycles(2);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234;
        wait_cycles(1);
        bus.hi_we = 1'b0;
        wait_cycles(1);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        wait_cycles(6);
        bus.start = 1'b0;
        wait_cycles(2);
        check("mthi_ignored_run", {32'h0, bus.hi}, {32'h0, prev_hi});
        wait_idle();

        // MTLO, then MTHI+MTLO together, in IDLE.
        bus.lo_we = 1'b1;
        bus.wdata = 32'hABCD;
        wait_cycles(1);
        bus.lo_we = 1'b0;
        check("mtlo_lo", {32'h0, bus.lo}, 64'hABCD);
        check("mtlo_hi_kept", {32'h0, bus.hi}, {32'h0, cur_hi});
        cur_lo = 32'hABCD;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h5555;
        wait_cycles(1);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("mtboth_hi", {32'h0, bus.hi}, 64'h5555);
        check("mtboth_lo", {32'h0, bus.lo}, 64'h5555);
        cur_hi = 32'h5555;
        cur_lo = 32'h5555;

        // Start wins over a simultaneous MTHI.
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD;
        start_op(2'b01, 32'd2, 32'd3, 32'h0, 32'd6);
        bus.hi_we = 1'b0;
        check("start_beats_mthi", {32'h0, bus.hi}, {32'h0, prev_hi});
        wait_idle();

        // Back-to-back: second start issued in the done cycle.
        start_op(2'b01, 32'd7, 32'd8, 32'h0, 32'd56);
        wait_cycles(33);
        start_op(2'b00, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();

        // Asynchronous reset mid-operation.
        start_op(2'b01, 32'hFFFFFFFF, 32'd3, 32'd2, 32'hFFFFFFFD);
        wait_cycles(10);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", {63'h0, bus.busy}, 64'h0);
        check("rst_mid_done", {63'h0, bus.done}, 64'h0);
        check("rst_mid_hi",   {32'h0, bus.hi}, 64'h0);
        check("rst_mid_lo",   {32'h0, bus.lo}, 64'h0);
        void'(sb.pop_back());
        cur_hi = '0;
        cur_lo = '0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_cycles(1);
        start_op(2'b01, 32'd5, 32'd5, 32'h0, 32'd25);
        wait_idle();

        wait_cycles(3);
        check("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
